// File: rtl/vga_scan_engine.sv
// vga_scan_engine: parametrised raster timing generator, pixel-word fetch requester,
// two-entry return FIFO, packed-word unpacker and matched-latency sync/blank pipeline.
// Every output for counter value (h,v) reaches the pins exactly LAT cycles after the
// counters held (h,v).
// Optional feature: define VGA_MARKER_EN to add the mark_x/mark_y marker overlay.
module vga_scan_engine #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 11,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 31,
    parameter int unsigned PIX_W    = 18,
    parameter int unsigned PPW      = 2,
    parameter int unsigned LAT      = 7,
    parameter bit          SYNC_POL = 1'b0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HCW     = $clog2(H_TOTAL),
    localparam int unsigned VCW     = $clog2(V_TOTAL),
    localparam int unsigned WW      = PIX_W * PPW
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic             word_req,
    output logic [HCW-1:0]   word_hcount,
    output logic [VCW-1:0]   word_vcount,
    input  logic [WW-1:0]    word_in,
    input  logic             word_valid,
    output logic [PIX_W-1:0] pix_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             blank_out,
    output logic [HCW-1:0]   hcount,
    output logic [VCW-1:0]   vcount,
    output logic             frame_start,
    output logic             underflow
`ifdef VGA_MARKER_EN
    ,
    input  logic [4*HCW-1:0] mark_x,
    input  logic [4*VCW-1:0] mark_y
`endif
);

    localparam int unsigned PW = (PPW > 1) ? $clog2(PPW) : 1;

    localparam logic [HCW-1:0] H_LAST   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0] V_LAST   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0] H_ACT    = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0] V_ACT    = VCW'(V_ACTIVE);
    localparam logic [HCW-1:0] HS_FIRST = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] HS_LAST  = HCW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [VCW-1:0] VS_FIRST = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] VS_LAST  = VCW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [PW-1:0]  PH_LAST  = PW'(PPW - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q;
    logic [HCW-1:0]   h_q, h_nx;
    logic [VCW-1:0]   v_q, v_nx;
    logic [PW-1:0]    ph_q, ph_nx;
    logic             frame_start_q;
    logic             word_req_q;
    logic             running;
    logic             h_last, v_last, frame_wrap, enter_idle, nx_active;

    // Live (undelayed) raster attributes of the current counter value
    logic             blank_live, hs_live, vs_live;

    // Delay stages 0..LAT-2; the output registers form the final stage
    logic [LAT-2:0]   blank_pipe, hs_pipe, vs_pipe, req_pipe;

    // Return FIFO
    logic [WW-1:0]    fifo_mem [2];
    logic             fifo_wp, fifo_rp;
    logic [1:0]       fifo_cnt;
    logic             fifo_empty, pop_slot, fifo_pop, fifo_push;
    logic [WW-1:0]    fifo_head;

    // Unpacker
    logic [WW-1:0]    shift_q;
    logic [WW-1:0]    word_sel;
    logic [PIX_W-1:0] pix_next;

    logic [PIX_W-1:0] pix_q;
    logic             blank_q, hs_q, vs_q, underflow_q;
    logic             mark_hit;

    // Next counter values for an advancing cycle and derived raster predicates
    always_comb begin
        running    = (state_q != StIdle);
        h_last     = (h_q == H_LAST);
        v_last     = (v_q == V_LAST);
        frame_wrap = h_last && v_last;
        enter_idle = running && frame_wrap && !run;
        h_nx       = h_last ? '0 : h_q + 1'b1;
        if (!h_last) begin
            v_nx = v_q;
        end else begin
            v_nx = v_last ? '0 : v_q + 1'b1;
        end
        // Word phase restarts at the left edge of each line
        if (h_last || ph_q == PH_LAST) begin
            ph_nx = '0;
        end else begin
            ph_nx = ph_q + 1'b1;
        end
        nx_active  = (h_nx < H_ACT) && (v_nx < V_ACT);
        blank_live = !(running && (h_q < H_ACT) && (v_q < V_ACT));
        hs_live    = (running && h_q >= HS_FIRST && h_q <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vs_live    = (running && v_q >= VS_FIRST && v_q <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    end

    // Run/stop FSM with raster counters and registered strobes aligned to the counters
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            h_q           <= '0;
            v_q           <= '0;
            ph_q          <= '0;
            frame_start_q <= 1'b0;
            word_req_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Counters already sit at (0,0), an active word-aligned pixel
                    frame_start_q <= run;
                    word_req_q    <= run;
                    if (run) begin
                        state_q <= StRun;
                    end
                end
                StRun, StDrain: begin
                    if (enter_idle) begin
                        state_q       <= StIdle;
                        h_q           <= '0;
                        v_q           <= '0;
                        ph_q          <= '0;
                        frame_start_q <= 1'b0;
                        word_req_q    <= 1'b0;
                    end else begin
                        state_q       <= run ? StRun : StDrain;
                        h_q           <= h_nx;
                        v_q           <= v_nx;
                        ph_q          <= ph_nx;
                        frame_start_q <= frame_wrap;
                        word_req_q    <= nx_active && (ph_nx == '0);
                    end
                end
                default: begin
                    state_q       <= StIdle;
                    frame_start_q <= 1'b0;
                    word_req_q    <= 1'b0;
                end
            endcase
        end
    end

    // Delay line for blank, syncs and request markers; reset loads idle values
    always_ff @(posedge clock) begin
        if (reset) begin
            blank_pipe <= '1;
            hs_pipe    <= {(LAT-1){~SYNC_POL}};
            vs_pipe    <= {(LAT-1){~SYNC_POL}};
            req_pipe   <= '0;
        end else begin
            blank_pipe <= {blank_pipe[LAT-3:0], blank_live};
            hs_pipe    <= {hs_pipe[LAT-3:0], hs_live};
            vs_pipe    <= {vs_pipe[LAT-3:0], vs_live};
            req_pipe   <= {req_pipe[LAT-3:0], word_req_q};
        end
    end

    // A request reaching the last delay stage means its first pixel loads the output now
    always_comb begin
        pop_slot   = req_pipe[LAT-2];
        fifo_empty = (fifo_cnt == 2'd0);
        fifo_pop   = pop_slot && !fifo_empty;
        // A same-cycle pop frees the slot a full FIFO would otherwise refuse
        fifo_push  = word_valid && ((fifo_cnt != 2'd2) || fifo_pop);
        fifo_head  = fifo_mem[fifo_rp];
    end

    // FIFO pointers and occupancy; flushed on reset and when the raster stops
    always_ff @(posedge clock) begin
        if (reset || enter_idle) begin
            fifo_wp  <= 1'b0;
            fifo_rp  <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wp <= ~fifo_wp;
            end
            if (fifo_pop) begin
                fifo_rp <= ~fifo_rp;
            end
            fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
        end
    end

    // FIFO storage
    always_ff @(posedge clock) begin
        if (fifo_push) begin
            fifo_mem[fifo_wp] <= word_in;
        end
    end

    // Select the word feeding the output: a fresh pop (zeros on underflow) or the remainder
    always_comb begin
        word_sel = shift_q;
        if (pop_slot) begin
            word_sel = fifo_empty ? '0 : fifo_head;
        end
        pix_next = word_sel[WW-1 -: PIX_W];
    end

    // Unpack shift register: pixel 0 sits in the MSBs, later pixels follow each cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= word_sel << PIX_W;
        end
    end

    // Sticky underflow: missing word at pop time or a word arriving to a full FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            underflow_q <= 1'b0;
        end else if ((pop_slot && fifo_empty) || (word_valid && !fifo_push)) begin
            underflow_q <= 1'b1;
        end
    end

`ifdef VGA_MARKER_EN
    logic [HCW-1:0] hc_pipe [LAT-1];
    logic [VCW-1:0] vc_pipe [LAT-1];

    // Delayed coordinates so markers line up with the pixels on the pins
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT - 1; i++) begin
                hc_pipe[i] <= '0;
                vc_pipe[i] <= '0;
            end
        end else begin
            hc_pipe[0] <= h_q;
            vc_pipe[0] <= v_q;
            for (int i = 1; i < LAT - 1; i++) begin
                hc_pipe[i] <= hc_pipe[i-1];
                vc_pipe[i] <= vc_pipe[i-1];
            end
        end
    end

    // Marker hit on any of the four column or row markers
    always_comb begin
        mark_hit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (hc_pipe[LAT-2] == mark_x[i*HCW +: HCW] ||
                vc_pipe[LAT-2] == mark_y[i*VCW +: VCW]) begin
                mark_hit = 1'b1;
            end
        end
    end
`else
    assign mark_hit = 1'b0;
`endif

    // Final output stage; blanking overrides both markers and fetched pixels
    always_ff @(posedge clock) begin
        if (reset) begin
            pix_q   <= '0;
            blank_q <= 1'b1;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
        end else begin
            blank_q <= blank_pipe[LAT-2];
            hs_q    <= hs_pipe[LAT-2];
            vs_q    <= vs_pipe[LAT-2];
            if (blank_pipe[LAT-2]) begin
                pix_q <= '0;
            end else if (mark_hit) begin
                pix_q <= '1;
            end else begin
                pix_q <= pix_next;
            end
        end
    end

    assign word_req    = word_req_q;
    assign word_hcount = h_q;
    assign word_vcount = v_q;
    assign hcount      = h_q;
    assign vcount      = v_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign pix_out     = pix_q;
    assign blank_out   = blank_q;
    assign hsync_out   = hs_q;
    assign vsync_out   = vs_q;

endmodule
